// File: rtl/xc_lag_correlator_pkg.sv
// rtl/xc_lag_correlator_pkg.sv - shared types and index helpers for the lag correlator
package xc_pkg;

    typedef enum logic {
        WIN_IDLE,
        WIN_INTEGRATE
    } win_state_e;

    typedef enum logic {
        RD_EMPTY,
        RD_STREAM
    } rd_state_e;

    // Never returns less than one bit, so single-entry indices still get a port.
    function automatic int clog2(input int value);
        int w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

    function automatic int base_idx(input int a, input int b, input int n);
        return a * (2 * n - a - 1) / 2 + b - a - 1;
    endfunction

    function automatic int word_idx(input int a, input int b, input int k,
                                    input int n, input int lags);
        return n + base_idx(a, b, n) * (2 * lags - 1) + k + lags - 1;
    endfunction

endpackage

// File: rtl/xc_lag_correlator_sat_counter.sv
// rtl/xc_lag_correlator_sat_counter.sv - saturating event counter with sticky overflow flag
module xc_sat_counter #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] value,
    output logic             sat
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             sat_q, sat_d;

    // value/sat already include this cycle's increment, so a snapshot taken on
    // the same edge as clear still sees the final sample of the window.
    always_comb begin
        value = count_q;
        sat   = sat_q;
        if (inc) begin
            if (&count_q) sat = 1'b1;
            else          value = count_q + WIDTH'(1);
        end
        count_d = clear ? '0   : value;
        sat_d   = clear ? 1'b0 : sat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

endmodule

// File: rtl/xc_lag_correlator.sv
// rtl/xc_lag_correlator.sv - N-input delayed lag correlator with windowed snapshot readout
module xc_lag_correlator
    import xc_pkg::*;
#(
    parameter int  NUM_INPUTS    = 4,
    parameter int  MAX_DELAY     = 64,
    parameter int  LAGS          = 4,
    parameter int  RESOLUTION    = 24,
    parameter int  WINDOW_WIDTH  = 32,
    localparam int NUM_BASELINES = NUM_INPUTS * (NUM_INPUTS - 1) / 2,
    localparam int NUM_WORDS     = NUM_INPUTS + NUM_BASELINES * (2 * LAGS - 1),
    localparam int IDX_W         = clog2(NUM_INPUTS),
    localparam int DLY_W         = clog2(MAX_DELAY + 1),
    localparam int WORD_W        = clog2(NUM_WORDS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_INPUTS-1:0]   sample_in,
    input  logic                    sample_valid,
    input  logic                    delay_wr,
    input  logic [IDX_W-1:0]        delay_idx,
    input  logic [DLY_W-1:0]        delay_val,
    input  logic [WINDOW_WIDTH-1:0] window_len,
    input  logic                    start,
    input  logic                    stop,
    output logic                    integrating,
    output logic [RESOLUTION-1:0]   out_data,
    output logic [WORD_W-1:0]       out_index,
    output logic                    out_sat,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [15:0]             dropped
);

    localparam int DEPTH  = MAX_DELAY + LAGS;
    localparam int LINE_W = clog2(DEPTH);

    logic [DEPTH-1:0]        line_q [NUM_INPUTS];
    logic [DEPTH-1:0]        line_d [NUM_INPUTS];
    logic [DLY_W-1:0]        delay_q [NUM_INPUTS];
    logic [DLY_W-1:0]        delay_d [NUM_INPUTS];
    logic                    acc_en_q, acc_en_d;
    win_state_e              win_state_q, win_state_d;
    logic [WINDOW_WIDTH-1:0] len_q, len_d, cnt_q, cnt_d, cnt_inc;
    rd_state_e               rd_state_q, rd_state_d;
    logic [WORD_W-1:0]       rd_idx_q, rd_idx_d;
    logic [RESOLUTION-1:0]   shadow_q [NUM_WORDS];
    logic [RESOLUTION-1:0]   shadow_d [NUM_WORDS];
    logic [NUM_WORDS-1:0]    shadow_sat_q, shadow_sat_d;
    logic [15:0]             dropped_q, dropped_d;

    logic [NUM_WORDS-1:0]    tap, acc_sat;
    logic [RESOLUTION-1:0]   acc_val [NUM_WORDS];
    logic                    acc_inc, acc_clear, window_end, snapshot;
    logic                    handshake, last_word, bank_free;

    always_comb begin
        acc_en_d = sample_valid;
        for (int n = 0; n < NUM_INPUTS; n++) begin
            line_d[n] = line_q[n];
            if (sample_valid) line_d[n] = {line_q[n][DEPTH-2:0], sample_in[n]};
        end
        delay_d = delay_q;
        if (delay_wr && win_state_q == WIN_IDLE && int'(delay_idx) < NUM_INPUTS) begin
            delay_d[delay_idx] = (delay_val > DLY_W'(MAX_DELAY)) ? DLY_W'(MAX_DELAY) : delay_val;
        end
    end

    for (genvar n = 0; n < NUM_INPUTS; n++) begin : g_chan
        assign tap[n] = line_q[n][LINE_W'(delay_q[n])];
    end

    // The earlier-arriving side of each pair is read deeper into its line.
    for (genvar a = 0; a < NUM_INPUTS; a++) begin : g_a
        for (genvar b = a + 1; b < NUM_INPUTS; b++) begin : g_b
            for (genvar j = 0; j < 2 * LAGS - 1; j++) begin : g_lag
                localparam int K     = j - (LAGS - 1);
                localparam int W     = word_idx(a, b, K, NUM_INPUTS, LAGS);
                localparam int OFF_A = (K < 0) ? -K : 0;
                localparam int OFF_B = (K > 0) ? K : 0;
                logic [LINE_W-1:0] pos_a, pos_b;
                assign pos_a  = LINE_W'(delay_q[a]) + LINE_W'(OFF_A);
                assign pos_b  = LINE_W'(delay_q[b]) + LINE_W'(OFF_B);
                assign tap[W] = line_q[a][pos_a] & line_q[b][pos_b];
            end
        end
    end

    for (genvar w = 0; w < NUM_WORDS; w++) begin : g_cnt
        xc_sat_counter #(.WIDTH(RESOLUTION)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clear (acc_clear),
            .inc   (acc_inc & tap[w]),
            .value (acc_val[w]),
            .sat   (acc_sat[w])
        );
    end

    always_comb begin
        acc_inc    = acc_en_q && (win_state_q == WIN_INTEGRATE);
        handshake  = (rd_state_q == RD_STREAM) && out_ready;
        last_word  = (rd_idx_q == WORD_W'(NUM_WORDS - 1));
        bank_free  = (rd_state_q == RD_EMPTY) || (handshake && last_word);
        cnt_inc    = cnt_q + WINDOW_WIDTH'(1);
        window_end = acc_inc && (cnt_inc == len_q);
        snapshot   = window_end && bank_free;

        win_state_d = win_state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        dropped_d   = dropped_q;
        acc_clear   = 1'b0;
        case (win_state_q)
            WIN_IDLE: begin
                if (start && !stop && window_len != '0) begin
                    win_state_d = WIN_INTEGRATE;
                    len_d       = window_len;
                    cnt_d       = '0;
                    acc_clear   = 1'b1;
                end
            end
            WIN_INTEGRATE: begin
                if (acc_inc) cnt_d = cnt_inc;
                if (window_end) begin
                    cnt_d     = '0;
                    acc_clear = 1'b1;
                    if (!bank_free && dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
                end
                if (stop) begin
                    win_state_d = WIN_IDLE;
                    acc_clear   = 1'b1;
                end
            end
            default: win_state_d = WIN_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d   = rd_state_q;
        rd_idx_d     = rd_idx_q;
        shadow_d     = shadow_q;
        shadow_sat_d = shadow_sat_q;
        if (handshake) begin
            if (last_word) begin
                rd_state_d = RD_EMPTY;
                rd_idx_d   = '0;
            end else begin
                rd_idx_d = rd_idx_q + WORD_W'(1);
            end
        end
        if (snapshot) begin
            rd_state_d   = RD_STREAM;
            rd_idx_d     = '0;
            shadow_d     = acc_val;
            shadow_sat_d = acc_sat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < NUM_INPUTS; n++) begin
                line_q[n]  <= '0;
                delay_q[n] <= '0;
            end
            acc_en_q     <= 1'b0;
            win_state_q  <= WIN_IDLE;
            len_q        <= '0;
            cnt_q        <= '0;
            rd_state_q   <= RD_EMPTY;
            rd_idx_q     <= '0;
            shadow_sat_q <= '0;
            dropped_q    <= '0;
        end else begin
            line_q       <= line_d;
            delay_q      <= delay_d;
            acc_en_q     <= acc_en_d;
            win_state_q  <= win_state_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            rd_state_q   <= rd_state_d;
            rd_idx_q     <= rd_idx_d;
            shadow_sat_q <= shadow_sat_d;
            dropped_q    <= dropped_d;
        end
    end

    // Shadow data is only observable through out_valid, so it carries no reset.
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

    assign integrating = (win_state_q == WIN_INTEGRATE);
    assign out_valid   = (rd_state_q == RD_STREAM);
    assign out_index   = rd_idx_q;
    assign out_data    = out_valid ? shadow_q[rd_idx_q] : '0;
    assign out_sat     = out_valid & shadow_sat_q[rd_idx_q];
    assign out_last    = out_valid & last_word;
    assign dropped     = dropped_q;

endmodule

// File: tb/tb_xc_lag_correlator.sv
// tb/tb_xc_lag_correlator.sv - directed self-checking bench for xc_lag_correlator
module tb_xc_lag_correlator;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  sample_in;
    logic        sample_valid;
    logic        delay_wr;
    logic [0:0]  delay_idx;
    logic [2:0]  delay_val;
    logic [15:0] window_len;
    logic        start;
    logic        stop;
    logic        integrating;
    logic [7:0]  out_data;
    logic [2:0]  out_index;
    logic        out_sat;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] dropped;

    int n_checks = 0;
    int n_fail   = 0;
    int got_data [5];
    int got_idx  [5];
    bit got_sat  [5];
    bit got_last [5];

    always #5 clk = ~clk;

    xc_lag_correlator #(
        .NUM_INPUTS   (2),
        .MAX_DELAY    (4),
        .LAGS         (2),
        .RESOLUTION   (8),
        .WINDOW_WIDTH (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .delay_wr     (delay_wr),
        .delay_idx    (delay_idx),
        .delay_val    (delay_val),
        .window_len   (window_len),
        .start        (start),
        .stop         (stop),
        .integrating  (integrating),
        .out_data     (out_data),
        .out_index    (out_index),
        .out_sat      (out_sat),
        .out_last     (out_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .dropped      (dropped)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic flush();
        sample_valid = 1'b1;
        sample_in    = 2'b00;
        tick(8);
    endtask

    task automatic begin_window(input int len, input logic [1:0] pattern);
        window_len = 16'(len);
        start      = 1'b1;
        sample_in  = pattern;
        tick(1);
        start      = 1'b0;
    endtask

    task automatic end_window();
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(8);
    endtask

    task automatic write_delay(input int idx, input int val);
        delay_wr  = 1'b1;
        delay_idx = 1'(idx);
        delay_val = 3'(val);
        tick(1);
        delay_wr  = 1'b0;
    endtask

    task automatic read_window();
        int n   = 0;
        int cyc = 0;
        while (n < 5 && cyc < 1000) begin
            if (out_valid && out_ready) begin
                got_data[n] = int'(out_data);
                got_idx[n]  = int'(out_index);
                got_sat[n]  = out_sat;
                got_last[n] = out_last;
                n++;
            end
            if (n < 5) begin
                tick(1);
                cyc++;
            end
        end
        check_eq("read_count", n, 5);
    endtask

    task automatic check_window(input string tag, input int e0, input int e1, input int e2,
                                input int e3, input int e4, input bit esat);
        int exp_data [5];
        exp_data = '{e0, e1, e2, e3, e4};
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
            check_eq($sformatf("%s_sat%0d", tag, i), {31'd0, got_sat[i]}, {31'd0, esat});
            check_eq($sformatf("%s_idx%0d", tag, i), got_idx[i], i);
            check_eq($sformatf("%s_last%0d", tag, i), {31'd0, got_last[i]}, (i == 4) ? 1 : 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int seen;
        reset        = 1'b1;
        sample_in    = 2'b00;
        sample_valid = 1'b0;
        delay_wr     = 1'b0;
        delay_idx    = '0;
        delay_val    = '0;
        window_len   = '0;
        start        = 1'b0;
        stop         = 1'b0;
        out_ready    = 1'b1;
        tick(3);
        check_eq("rst_integrating", integrating, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_last", out_last, 0);
        check_eq("rst_out_sat", out_sat, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_index", out_index, 0);
        check_eq("rst_dropped", dropped, 0);
        reset = 1'b0;

        // zero-length window must not start
        window_len = '0;
        start      = 1'b1;
        tick(1);
        start      = 1'b0;
        check_eq("zero_len_ignored", integrating, 0);

        flush();
        begin_window(10, 2'b11);
        check_eq("basic_integrating", integrating, 1);
        read_window();
        check_window("basic", 10, 10, 9, 10, 9, 1'b0);
        end_window();

        write_delay(1, 1);
        flush();
        begin_window(8, 2'b00);
        sample_in = 2'b11;
        tick(1);
        sample_in = 2'b00;
        read_window();
        check_window("delay", 1, 1, 1, 0, 0, 1'b0);
        end_window();
        write_delay(1, 0);

        flush();
        begin_window(300, 2'b11);
        read_window();
        check_window("sat", 255, 255, 255, 255, 255, 1'b1);
        end_window();
        flush();
        begin_window(10, 2'b11);
        read_window();
        check_window("post_sat", 10, 10, 9, 10, 9, 1'b0);
        end_window();

        flush();
        out_ready = 1'b0;
        begin_window(4, 2'b11);
        cyc = 0;
        while (dropped != 16'd2 && cyc < 100) begin
            tick(1);
            cyc++;
        end
        check_eq("bp_dropped", dropped, 2);
        check_eq("bp_valid", out_valid, 1);
        check_eq("bp_hold_idx", out_index, 0);
        check_eq("bp_hold_data", out_data, 4);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(6);
        check_eq("bp_dropped_after_stop", dropped, 2);
        check_eq("bp_hold_idx2", out_index, 0);
        check_eq("bp_hold_data2", out_data, 4);
        out_ready = 1'b1;
        read_window();
        check_window("bp", 4, 4, 3, 4, 3, 1'b0);
        tick(4);
        check_eq("bp_drained", out_valid, 0);

        flush();
        begin_window(10, 2'b11);
        tick(4);
        check_eq("stop_pre_integrating", integrating, 1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        check_eq("stop_integrating", integrating, 0);
        seen = 0;
        repeat (20) begin
            if (out_valid) seen++;
            tick(1);
        end
        check_eq("stop_no_words", seen, 0);

        flush();
        begin_window(10, 2'b11);
        write_delay(1, 1);
        read_window();
        check_window("wr_ignored", 10, 10, 9, 10, 9, 1'b0);
        end_window();

        flush();
        out_ready = 1'b0;
        begin_window(10, 2'b11);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            tick(1);
            cyc++;
        end
        check_eq("mid_valid", out_valid, 1);
        check_eq("mid_dropped", dropped, 2);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_integrating", integrating, 0);
        check_eq("mid_rst_dropped", dropped, 0);
        check_eq("mid_rst_index", out_index, 0);
        out_ready = 1'b1;
        flush();
        begin_window(10, 2'b11);
        read_window();
        check_window("post_rst", 10, 10, 9, 10, 9, 1'b0);
        end_window();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xc_lag_correlator.md
Name: xc_lag_correlator

Overview:
- Parametrised successor to the per-line pulse correlator. Covers N inputs, programmable per-channel delay, and a symmetric band of ±(LAGS-1) lags per baseline.
- Integrates over a programmable sample window with zero dead time between windows.
- At window end, snapshots all counters into a shadow bank. The bank is then streamed out as indexed words over a valid/ready interface, which feeds the packetiser/UART TX path.
- Replaces free-running reset-on-integration-clock counters with an explicit window FSM, saturation flags and drop accounting.

Parameters:
NUM_INPUTS, 4, number of 1-bit input lines
MAX_DELAY, 64, largest programmable per-channel delay, in samples
LAGS, 4, one-sided lag count; lags run -(LAGS-1)..+(LAGS-1)
RESOLUTION, 24, counter and output word width
WINDOW_WIDTH, 32, width of window_len
NUM_BASELINES, NUM_INPUTS*(NUM_INPUTS-1)/2, derived; do not override
NUM_WORDS, NUM_INPUTS+NUM_BASELINES*(2*LAGS-1), derived; words per window

Ports:
clk  in  1  sampling clock; single clock domain
reset  in  1  synchronous, active-high
sample_in  in  NUM_INPUTS  one bit per line
sample_valid  in  1  qualifies sample_in
delay_wr  in  1  write strobe for the delay table
delay_idx  in  clog2(NUM_INPUTS)  channel being written
delay_val  in  clog2(MAX_DELAY+1)  delay value; clamped to MAX_DELAY
window_len  in  WINDOW_WIDTH  samples per window; latched on start
start  in  1  begin integrating; ignored unless IDLE and window_len!=0
stop  in  1  abort the current window and return to IDLE
integrating  out  1  high while in INTEGRATE
out_data  out  RESOLUTION  counter value
out_index  out  clog2(NUM_WORDS)  word index within the window
out_sat  out  1  this counter saturated during the window
out_last  out  1  asserted with index NUM_WORDS-1
out_valid  out  1  stream valid
out_ready  in  1  stream ready
dropped  out  16  windows discarded because the shadow bank was busy; saturating

Behaviour:
- Reset values: integrating=0, out_valid=0, out_last=0, out_sat=0, out_data=0, out_index=0, dropped=0. Additionally, all delays=0, all line and accumulator bits=0, shadow bank empty.
- Delay line:
  - Per channel depth MAX_DELAY+LAGS.
  - On sample_valid: line[0]<=sample_in and line[i]<=line[i-1].
  - acc_en is sample_valid registered one cycle. Counters sample the line state after the shift.
- Tap definitions, with d_n the delay of channel n:
  - Channel word n counts line[d_n][n].
  - Baseline (a<b), lag k counts line[d_a+max(-k,0)][a] AND line[d_b+max(k,0)][b].
- Word order per window:
  - Channel words 0..NUM_INPUTS-1 first.
  - Then baselines (0,1),(0,2)..(0,N-1),(1,2)..; within each baseline, lag -(LAGS-1) up to +(LAGS-1).
- Counters saturate at 2^RESOLUTION-1 and set a per-word sticky sat bit. Both counter and sat bit clear on window end.
- delay_wr is accepted only in IDLE; it is ignored otherwise. The new delay is effective from the next acc_en.
- Window FSM, states IDLE and INTEGRATE:
  - IDLE->INTEGRATE on start with window_len!=0. This clears accumulators, clears the sample counter and latches window_len.
  - In INTEGRATE, the sample counter increments per acc_en.
  - On the acc_en that reaches window_len, that cycle's increment is included. If the shadow bank is empty, accumulators and sat bits copy to shadow. Otherwise dropped increments, saturating at 0xFFFF.
  - In both cases, accumulators and the counter clear the same cycle and integration continues with no lost sample.
  - stop in INTEGRATE: go to IDLE, discard the partial window, clear accumulators. A stop coinciding with window end still snapshots that window first.
  - start and stop together: stop wins.
- Readout FSM, states EMPTY and STREAM:
  - Snapshot -> STREAM, with out_valid asserted the next cycle and out_index=0.
  - A word advances only on out_valid&&out_ready. out_data, out_index, out_sat and out_last are held stable while out_valid&&!out_ready.
  - After the handshake of the out_last word -> EMPTY. The bank is free the same cycle, so a window ending that cycle is stored, not dropped.
  - Readout is independent of stop and continues after the window FSM returns to IDLE.
- Reset mid-operation returns both FSMs to their initial states, discarding any shadow contents.

Decomposition:
- Shared package xc_pkg:
  - clog2 function.
  - Baseline-index function: base(a,b)=a*(2N-a-1)/2+b-a-1.
  - Word-index function: NUM_INPUTS+base*(2*LAGS-1)+k+LAGS-1.
  - FSM state encodings.
- One natural sub-module: xc_sat_counter, a RESOLUTION-bit saturating counter. Its ports are clk, reset, clear, inc and snapshot-safe value, plus the sticky sat bit. It is instantiated once per word.

Test Plan:
- Reset: assert reset for 3 cycles mid-stream -> out_valid=0, integrating=0, dropped=0. Next start is accepted normally.
- N=2, LAGS=2, RES=8, delays 0, both inputs held 1, window_len=10, out_ready=1 -> 5 words 10,10,9,10,9 (lags -1 and +1 miss the zero-primed first tap). out_last on index 4.
- Delay: d0=0, d1=1, single coincident pulse on both lines, window_len=8 -> baseline words lag-1=1, lag0=0, lag+1=0. Channel words are 1 each.
- Saturation: RES=8, all-ones input, window_len=300 -> every word 255 with out_sat=1. The next window of 10 reads 10/9 with out_sat=0.
- Backpressure: out_ready=0, window_len=4, run 3 windows -> dropped=2, first word held stable. Then raise out_ready -> the window-1 words stream in order with out_last on the 5th handshake.
- Stop and ignored writes: stop at sample 5 of 10 -> no words emitted, integrating=0 next cycle. delay_wr during INTEGRATE has no effect on subsequent counts.
